xyolo_write_ctrl: RTL and testbench

- Sequencer for the xyolo write stage.
- Generates the internal (port B) address streams: vread_enB/vread_addrB for pixel reads, and vwrite_enB/vwrite_addrB for result writes.
- Generates the xyolo load strobes ld_acc/ld_mp/ld_res, aligned to the stage's fixed pipeline latencies.
- Runs one convolution/maxpool tile per run pulse and reports completion via done.

---
 rtl/xyolo_write_ctrl_pkg.sv | 42 ++++
 rtl/xyolo_ctrl_dly.sv | 22 ++
 rtl/xyolo_write_ctrl.sv | 152 +++++++++++++++
 tb/tb_xyolo_write_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/xyolo_write_ctrl_pkg.sv
// Shared constants, FSM encoding and read-event helper for the xyolo write-stage sequencer.
package xyolo_write_ctrl_pkg;

   localparam int unsigned N_LANES = 16;
   localparam int unsigned RADDR_W = 13;
   localparam int unsigned WADDR_W = 10;
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned PIX_LAT = 2;
   localparam int unsigned RES_LAT = 3;

   // Write strobe is pre-registered one stage early so its address can be registered with it.
   localparam int unsigned RES_DLY    = PIX_LAT + 1;
   localparam int unsigned WR_PRE_DLY = RES_DLY + RES_LAT - 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic first;
      logic last;
      logic mp;
      logic wr;
   } rd_evt_t;

   // Strobe events tied to the pixel read at position (k, o) of a tile.
   function automatic rd_evt_t rd_evt(input logic [CNT_W-1:0] k,
                                      input logic [CNT_W-1:0] o,
                                      input logic [CNT_W-1:0] nacc,
                                      input logic [CNT_W-1:0] nout,
                                      input logic             maxpool);
      rd_evt_t e;
      e.first = (k == '0);
      e.last  = (k == nacc - CNT_W'(1));
      e.mp    = e.last & maxpool & (o[1:0] == 2'd0);
      e.wr    = e.last & (~maxpool | (o[1:0] == 2'd3) | (o == nout - CNT_W'(1)));
      return e;
   endfunction

endpackage

// File: rtl/xyolo_ctrl_dly.sv
// Single-bit shift-register delay with synchronous clear and an occupancy flag.
module xyolo_ctrl_dly #(
   parameter int unsigned DEPTH = 2
) (
   input  logic clk,
   input  logic clr,
   input  logic din,
   output logic dout,
   output logic busy
);

   logic [DEPTH-1:0] sr;

   always_ff @(posedge clk) begin
      if (clr) sr <= '0;
      else     sr <= DEPTH'({sr, din});
   end

   assign dout = sr[DEPTH-1];
   assign busy = |sr;

endmodule

// File: rtl/xyolo_write_ctrl.sv
// xyolo write-stage sequencer: pixel read addresses, load strobes and result writes per tile.
module xyolo_write_ctrl
   import xyolo_write_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   output logic               done,
   input  logic [RADDR_W-1:0] cfg_raddr_start,
   input  logic [RADDR_W-1:0] cfg_out_incr,
   input  logic [CNT_W-1:0]   cfg_nacc,
   input  logic [CNT_W-1:0]   cfg_nout,
   input  logic               cfg_maxpool,
   input  logic [WADDR_W-1:0] cfg_waddr_start,
   output logic               vread_enB,
   output logic [RADDR_W-1:0] vread_addrB,
   output logic [N_LANES-1:0] vwrite_enB,
   output logic [WADDR_W-1:0] vwrite_addrB,
   output logic               ld_acc,
   output logic               ld_mp,
   output logic               ld_res
);

   state_t             state;
   logic [CNT_W-1:0]   nacc_q, nout_q, k_q, o_q;
   logic [RADDR_W-1:0] incr_q, base_q;
   logic               maxpool_q;
   logic [WADDR_W-1:0] waddr_q;
   rd_evt_t            evt_q;

   logic [CNT_W-1:0]   nxt_k, nxt_o, cur_nacc, cur_nout;
   logic [RADDR_W-1:0] nxt_base, nxt_addr;
   logic               cur_maxpool, rd_done, lines_empty;
   rd_evt_t            nxt_evt;

   logic wr_pre, acc_busy, res_busy, mp_busy, wr_busy;

   // Next pixel to read: first pixel of the tile from IDLE, otherwise advance (k, o).
   always_comb begin
      nxt_k       = '0;
      nxt_o       = '0;
      nxt_base    = cfg_raddr_start;
      cur_nacc    = cfg_nacc;
      cur_nout    = cfg_nout;
      cur_maxpool = cfg_maxpool;
      if (state != ST_IDLE) begin
         cur_nacc    = nacc_q;
         cur_nout    = nout_q;
         cur_maxpool = maxpool_q;
         if (evt_q.last) begin
            nxt_o    = o_q + CNT_W'(1);
            nxt_base = base_q + incr_q;
         end else begin
            nxt_k    = k_q + CNT_W'(1);
            nxt_o    = o_q;
            nxt_base = base_q;
         end
      end
      nxt_addr    = nxt_base + RADDR_W'(nxt_k);
      nxt_evt     = rd_evt(nxt_k, nxt_o, cur_nacc, cur_nout, cur_maxpool);
      rd_done     = (state == ST_READ) && evt_q.last && (o_q == nout_q - CNT_W'(1));
      lines_empty = ~(acc_busy | res_busy | mp_busy | wr_busy);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         done         <= 1'b1;
         nacc_q       <= '0;
         nout_q       <= '0;
         incr_q       <= '0;
         maxpool_q    <= 1'b0;
         k_q          <= '0;
         o_q          <= '0;
         base_q       <= '0;
         waddr_q      <= '0;
         evt_q        <= '0;
         vread_enB    <= 1'b0;
         vread_addrB  <= '0;
         vwrite_enB   <= '0;
         vwrite_addrB <= '0;
      end else begin
         vwrite_enB   <= wr_pre ? '1 : '0;
         vwrite_addrB <= wr_pre ? waddr_q : '0;
         if (wr_pre) waddr_q <= waddr_q + WADDR_W'(1);

         case (state)
            ST_IDLE: begin
               if (run) begin
                  nacc_q    <= cfg_nacc;
                  nout_q    <= cfg_nout;
                  incr_q    <= cfg_out_incr;
                  maxpool_q <= cfg_maxpool;
                  waddr_q   <= cfg_waddr_start;
                  done      <= 1'b0;
                  if (cfg_nacc == '0 || cfg_nout == '0) begin
                     state <= ST_DRAIN;
                  end else begin
                     state       <= ST_READ;
                     vread_enB   <= 1'b1;
                     vread_addrB <= nxt_addr;
                     k_q         <= nxt_k;
                     o_q         <= nxt_o;
                     base_q      <= nxt_base;
                     evt_q       <= nxt_evt;
                  end
               end
            end
            ST_READ: begin
               if (rd_done) begin
                  state       <= ST_DRAIN;
                  vread_enB   <= 1'b0;
                  vread_addrB <= '0;
                  evt_q       <= '0;
                  k_q         <= '0;
                  o_q         <= '0;
               end else begin
                  vread_addrB <= nxt_addr;
                  k_q         <= nxt_k;
                  o_q         <= nxt_o;
                  base_q      <= nxt_base;
                  evt_q       <= nxt_evt;
               end
            end
            ST_DRAIN: begin
               if (lines_empty) begin
                  state <= ST_IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   xyolo_ctrl_dly #(.DEPTH(PIX_LAT)) u_dly_acc (
      .clk(clk), .clr(rst), .din(evt_q.first), .dout(ld_acc), .busy(acc_busy)
   );

   xyolo_ctrl_dly #(.DEPTH(RES_DLY)) u_dly_res (
      .clk(clk), .clr(rst), .din(evt_q.last), .dout(ld_res), .busy(res_busy)
   );

   xyolo_ctrl_dly #(.DEPTH(RES_DLY)) u_dly_mp (
      .clk(clk), .clr(rst), .din(evt_q.mp), .dout(ld_mp), .busy(mp_busy)
   );

   xyolo_ctrl_dly #(.DEPTH(WR_PRE_DLY)) u_dly_wr (
      .clk(clk), .clr(rst), .din(evt_q.wr), .dout(wr_pre), .busy(wr_busy)
   );

endmodule

// File: tb/tb_xyolo_write_ctrl.sv
// Scoreboard bench for xyolo_write_ctrl: per-cycle expected output trace built from a cycle model.
module tb_xyolo_write_ctrl;
   import xyolo_write_ctrl_pkg::*;

   localparam int unsigned MAXC = 64;

   logic               clk = 1'b0;
   logic               rst, run, done;
   logic [RADDR_W-1:0] cfg_raddr_start, cfg_out_incr;
   logic [CNT_W-1:0]   cfg_nacc, cfg_nout;
   logic               cfg_maxpool;
   logic [WADDR_W-1:0] cfg_waddr_start;
   logic               vread_enB;
   logic [RADDR_W-1:0] vread_addrB;
   logic [N_LANES-1:0] vwrite_enB;
   logic [WADDR_W-1:0] vwrite_addrB;
   logic               ld_acc, ld_mp, ld_res;

   typedef struct packed {
      logic               done;
      logic               rd_en;
      logic [RADDR_W-1:0] rd_addr;
      logic [N_LANES-1:0] wr_en;
      logic [WADDR_W-1:0] wr_addr;
      logic               ld_acc;
      logic               ld_mp;
      logic               ld_res;
   } obs_t;

   obs_t        exp_q[$];
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clk = ~clk;

   xyolo_write_ctrl dut (
      .clk(clk), .rst(rst), .run(run), .done(done),
      .cfg_raddr_start(cfg_raddr_start), .cfg_out_incr(cfg_out_incr),
      .cfg_nacc(cfg_nacc), .cfg_nout(cfg_nout), .cfg_maxpool(cfg_maxpool),
      .cfg_waddr_start(cfg_waddr_start),
      .vread_enB(vread_enB), .vread_addrB(vread_addrB),
      .vwrite_enB(vwrite_enB), .vwrite_addrB(vwrite_addrB),
      .ld_acc(ld_acc), .ld_mp(ld_mp), .ld_res(ld_res)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   function automatic obs_t idle_obs();
      obs_t r = '0;
      r.done = 1'b1;
      return r;
   endfunction

   function automatic obs_t sample();
      obs_t r;
      r.done    = done;
      r.rd_en   = vread_enB;
      r.rd_addr = vread_addrB;
      r.wr_en   = vwrite_enB;
      r.wr_addr = vwrite_addrB;
      r.ld_acc  = ld_acc;
      r.ld_mp   = ld_mp;
      r.ld_res  = ld_res;
      return r;
   endfunction

   // Builds the expected trace for cycles c0..ncyc-1 (run high in c0), then drives and compares.
   task automatic run_case(input string name, input int nacc, input int nout,
                           input logic [RADDR_W-1:0] rstart, input logic [RADDR_W-1:0] incr,
                           input logic [WADDR_W-1:0] wstart, input logic mp,
                           input int ncyc, input int rst_at, input int rerun_at);
      obs_t e [MAXC];
      obs_t got, want;
      int   widx, last_wr;
      for (int c = 0; c < int'(MAXC); c++) e[c] = idle_obs();
      if (nacc * nout == 0) begin
         e[1].done = 1'b0;
      end else begin
         widx    = 0;
         last_wr = 0;
         for (int i = 0; i < nacc * nout; i++) begin
            int o, k, cy;
            o  = i / nacc;
            k  = i % nacc;
            cy = 1 + i;
            e[cy].rd_en   = 1'b1;
            e[cy].rd_addr = RADDR_W'(rstart + o * incr + k);
            if (k == 0) e[cy + 2].ld_acc = 1'b1;
            if (k == nacc - 1) begin
               e[cy + 3].ld_res = 1'b1;
               if (mp && (o % 4 == 0)) e[cy + 3].ld_mp = 1'b1;
               if (!mp || (o % 4 == 3) || (o == nout - 1)) begin
                  e[cy + 6].wr_en   = '1;
                  e[cy + 6].wr_addr = WADDR_W'(wstart + widx);
                  widx++;
                  last_wr = cy + 6;
               end
            end
         end
         for (int c = 1; c <= last_wr; c++) e[c].done = 1'b0;
      end
      if (rst_at >= 0)
         for (int c = rst_at + 1; c < ncyc; c++) e[c] = idle_obs();
      for (int c = 0; c < ncyc; c++) exp_q.push_back(e[c]);

      for (int c = 0; c < ncyc; c++) begin
         @(posedge clk);
         #1;
         run = (c == 0) || (c == rerun_at);
         rst = (c == rst_at);
         if (c == 0) begin
            cfg_nacc        = CNT_W'(nacc);
            cfg_nout        = CNT_W'(nout);
            cfg_raddr_start = rstart;
            cfg_out_incr    = incr;
            cfg_waddr_start = wstart;
            cfg_maxpool     = mp;
         end else begin
            cfg_nacc        = CNT_W'($urandom_range(1, 7));
            cfg_nout        = CNT_W'($urandom_range(1, 7));
            cfg_raddr_start = RADDR_W'($urandom);
            cfg_out_incr    = RADDR_W'($urandom);
            cfg_waddr_start = WADDR_W'($urandom);
            cfg_maxpool     = 1'($urandom);
         end
         @(negedge clk);
         got  = sample();
         want = exp_q.pop_front();
         // Addresses are only meaningful under their enable while a tile is in flight.
         if (!want.done && !want.rd_en) got.rd_addr = '0;
         if (!want.done && (want.wr_en == '0)) got.wr_addr = '0;
         check($sformatf("%s c%0d", name, c), 64'(got), 64'(want));
      end
      @(posedge clk);
      #1;
      run = 1'b0;
      rst = 1'b0;
   endtask

   initial begin
      obs_t want;
      rst = 1'b1;
      run = 1'b0;
      cfg_raddr_start = '0;
      cfg_out_incr    = '0;
      cfg_nacc        = '0;
      cfg_nout        = '0;
      cfg_maxpool     = 1'b0;
      cfg_waddr_start = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      exp_q.push_back(idle_obs());
      want = exp_q.pop_front();
      check("reset", 64'(sample()), 64'(want));

      run_case("basic",      3, 2, 13'd5,    13'd8,  10'd0,    1'b0, 16, -1, -1);
      run_case("maxpool6",   1, 6, 13'd100,  13'd3,  10'd0,    1'b1, 16, -1, -1);
      run_case("zero_nout",  2, 0, 13'd7,    13'd1,  10'd5,    1'b0,  5, -1, -1);
      run_case("zero_nacc",  0, 3, 13'd7,    13'd1,  10'd5,    1'b1,  5, -1, -1);
      run_case("busy_rerun", 3, 2, 13'd5,    13'd8,  10'd0,    1'b0, 16, -1,  3);
      run_case("rst_mid",    3, 2, 13'd5,    13'd8,  10'd0,    1'b0, 12,  4, -1);
      run_case("rst_vs_run", 3, 2, 13'd5,    13'd8,  10'd0,    1'b0,  6,  0, -1);
      run_case("wrap",       4, 2, 13'd8190, 13'd10, 10'd1023, 1'b0, 18, -1, -1);
      run_case("maxpool9",   2, 9, 13'd40,   13'd2,  10'd300,  1'b1, 28, -1, -1);
      run_case("nacc1",      1, 3, 13'd0,    13'd1,  10'd9,    1'b0, 12, -1, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
